nbym_b2_integer_divider_posr_seq: RTL

Sequential, parametrised two's-complement integer divider computing x / y for an N-bit dividend and M-bit divisor, with Euclidean semantics (remainder always non-negative). It replaces the fixed 4/2-digit combinational divider with an iterative restoring datapath and a start/done handshake, trading latency for area. It sits on the arithmetic unit's bus side. The host asserts `start` with operands and collects `q`, `r` and `no_idiv` when `done` pulses.

---
 rtl/nbym_b2_integer_divider_posr_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/nbym_b2_integer_divider_posr_seq.sv
// Sequential two's-complement integer divider with Euclidean semantics.
// A restoring datapath produces one quotient bit per cycle. A start/done
// handshake hands the quotient, the non-negative remainder and a flag that
// marks a division that cannot be represented (zero divisor or quotient out
// of range).
module nbym_b2_integer_divider_posr_seq #(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [M-1:0] y,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] q,
    output logic [M-1:0] r,
    output logic         no_idiv
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // Largest quotient magnitudes that still fit in M-bit two's complement
    localparam logic [N:0] MAX_POS = (N+1)'((1 << (M-1)) - 1);
    localparam logic [N:0] MAX_NEG = (N+1)'(1 << (M-1));

    logic [1:0]    state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [N-1:0]  shift_q,  shift_d;
    logic [M-1:0]  rem_q,    rem_d;
    logic [M-1:0]  yMag_q,   yMag_d;
    logic          xSgn_q,   xSgn_d;
    logic          ySgn_q,   ySgn_d;
    logic          yZero_q,  yZero_d;
    logic [M-1:0]  qOut_q,   qOut_d;
    logic [M-1:0]  rOut_q,   rOut_d;
    logic          noIdiv_q, noIdiv_d;
    logic          done_q,   done_d;

    logic [M:0]    partial;
    logic [M:0]    diff;
    logic          geq;
    logic          adjust;
    logic [N:0]    qMag;
    logic [M-1:0]  qTrunc;
    logic          qSgn;
    logic          overflow;

    // Restoring step and final sign fix-up, both derived from the registered
    // datapath. The shift register pushes dividend bits out at the top while
    // quotient bits enter at the bottom, so after N steps it holds |q|.
    always_comb begin
        partial  = {rem_q, shift_q[N-1]};
        diff     = partial - {1'b0, yMag_q};
        geq      = (partial >= {1'b0, yMag_q});
        adjust   = xSgn_q & (rem_q != '0);
        qMag     = {1'b0, shift_q} + {{N{1'b0}}, adjust};
        qTrunc   = qMag[M-1:0];
        qSgn     = xSgn_q ^ ySgn_q;
        overflow = qSgn ? (qMag > MAX_NEG) : (qMag > MAX_POS);
    end

    // Next-state logic for the IDLE -> ITER -> FIX sequence
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        rem_d    = rem_q;
        yMag_d   = yMag_q;
        xSgn_d   = xSgn_q;
        ySgn_d   = ySgn_q;
        yZero_d  = yZero_q;
        qOut_d   = qOut_q;
        rOut_d   = rOut_q;
        noIdiv_d = noIdiv_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    xSgn_d  = x[N-1];
                    ySgn_d  = y[M-1];
                    shift_d = x[N-1] ? (N'(0) - x) : x;
                    yMag_d  = y[M-1] ? (M'(0) - y) : y;
                    yZero_d = (y == '0);
                    rem_d   = '0;
                    cnt_d   = CW'(N - 1);
                    state_d = ITER;
                end
            end
            ITER: begin
                rem_d   = geq ? diff[M-1:0] : partial[M-1:0];
                shift_d = {shift_q[N-2:0], geq};
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                qOut_d   = qSgn ? (M'(0) - qTrunc) : qTrunc;
                rOut_d   = adjust ? (yMag_q - rem_q) : rem_q;
                noIdiv_d = yZero_q | overflow;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset wins over everything, including start
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            rem_q    <= '0;
            yMag_q   <= '0;
            xSgn_q   <= 1'b0;
            ySgn_q   <= 1'b0;
            yZero_q  <= 1'b0;
            qOut_q   <= '0;
            rOut_q   <= '0;
            noIdiv_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            rem_q    <= rem_d;
            yMag_q   <= yMag_d;
            xSgn_q   <= xSgn_d;
            ySgn_q   <= ySgn_d;
            yZero_q  <= yZero_d;
            qOut_q   <= qOut_d;
            rOut_q   <= rOut_d;
            noIdiv_q <= noIdiv_d;
            done_q   <= done_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign q       = qOut_q;
    assign r       = rOut_q;
    assign no_idiv = noIdiv_q;

endmodule
